// File: rtl/meh16_flags_pkg.sv
// ---------------------------------------------------------------------------
// meh16_flags_pkg
// Shared definitions for the MEH16 flag controller: flag bit positions inside
// the {S,C,Z} flag word, branch-condition select codes, the carry-tracking
// FSM state type, the default save-stack depth and the condition evaluator.
// ---------------------------------------------------------------------------
package meh16_flags_pkg;

    localparam int FLAG_W = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;

    localparam int DEFAULT_STACK_DEPTH = 4;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;
    localparam logic [2:0] COND_S      = 3'd5;
    localparam logic [2:0] COND_NS     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_ALU = 2'd1,
        PEND_A   = 2'd2
    } carry_state_t;

    function automatic logic cond_eval(input logic [2:0] sel,
                                       input logic [FLAG_W-1:0] flags);
        logic taken;
        taken = 1'b0;
        case (sel)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = flags[FLAG_Z];
            COND_NZ:     taken = !flags[FLAG_Z];
            COND_C:      taken = flags[FLAG_C];
            COND_NC:     taken = !flags[FLAG_C];
            COND_S:      taken = flags[FLAG_S];
            COND_NS:     taken = !flags[FLAG_S];
            default:     taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/flag_ctrl_stack.sv
// ---------------------------------------------------------------------------
// flag_stack
// DEPTH-entry LIFO of flag words used to save/restore flags around interrupts.
// Entry 0 is always the top of stack; a push shifts every entry down by one and
// a pop shifts everything up, so no variable indexing is needed.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (empties the stack)
//   push, pop - push data / pop top; ignored when full / empty respectively
//   data      - flag word to push
//   full      - stack holds DEPTH entries
//   empty     - stack holds no entries
//   top       - current top-of-stack entry (meaningless when empty)
// ---------------------------------------------------------------------------
module flag_stack
    import meh16_flags_pkg::*;
#(
    parameter int DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLAG_W-1:0] data,
    output logic              full,
    output logic              empty,
    output logic [FLAG_W-1:0] top
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLAG_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign top   = mem[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
            mem[DEPTH-1] <= '0;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/flag_ctrl.sv
// ---------------------------------------------------------------------------
// flag_ctrl
// Flag register {S,C,Z} for the MEH16 core. Z/S follow the accumulator every
// cycle, C is committed one cycle after an ALU or A-unit op, flags can be
// written explicitly, saved/restored through a small LIFO, and queried as
// branch conditions.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   a_out[15:0]              - accumulator value (Z and S source)
//   alu_op, a_op             - op issued this cycle, carry arrives next cycle
//   alu_c_flag, a_c_flag     - carry results matching alu_op / a_op
//   flag_wr, flag_wr_data    - explicit whole-flag write
//   save_req / save_ack      - push-flags handshake
//   restore_req/restore_ack  - pop-flags handshake
//   cond_req, cond_sel       - branch-condition query
//   cond_ack, cond_taken     - query acknowledge and held result
//   flags_out[2:0]           - {S,C,Z}
//   busy                     - carry commit pending
//   stk_err[1:0]             - sticky {underflow, overflow}
// ---------------------------------------------------------------------------
module flag_ctrl
    import meh16_flags_pkg::*;
#(
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       a_out,
    input  logic              alu_op,
    input  logic              a_op,
    input  logic              alu_c_flag,
    input  logic              a_c_flag,
    input  logic              flag_wr,
    input  logic [FLAG_W-1:0] flag_wr_data,
    input  logic              save_req,
    output logic              save_ack,
    input  logic              restore_req,
    output logic              restore_ack,
    input  logic              cond_req,
    input  logic [2:0]        cond_sel,
    output logic              cond_ack,
    output logic              cond_taken,
    output logic [FLAG_W-1:0] flags_out,
    output logic              busy,
    output logic [1:0]        stk_err
);

    carry_state_t      state;
    logic              restore_acc;
    logic              save_acc;
    logic              cond_acc;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [FLAG_W-1:0] stk_top;

    assign busy = (state != IDLE);

    // A request seen while its own ack is high is the tail of the previous
    // handshake, never a new one. Restore outranks save so push and pop never
    // collide; queries wait out pending carries and any flag overwrite.
    always_comb begin
        restore_acc = restore_req && !restore_ack;
        save_acc    = save_req && !save_ack && !busy && !restore_acc;
        cond_acc    = cond_req && !cond_ack && !busy && !flag_wr && !restore_acc;
        stk_push    = save_acc && !stk_full;
        stk_pop     = restore_acc && !stk_empty;
    end

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .data  (flags_out),
        .full  (stk_full),
        .empty (stk_empty),
        .top   (stk_top)
    );

    // Restore and flag_wr both replace the flag word outright and kill any
    // pending carry; otherwise Z/S track a_out and the pending carry commits
    // while a new op (alu_op preferred) is captured on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_out   <= 3'b001;
            state       <= IDLE;
            stk_err     <= 2'b00;
            save_ack    <= 1'b0;
            restore_ack <= 1'b0;
            cond_ack    <= 1'b0;
            cond_taken  <= 1'b0;
        end else begin
            save_ack    <= save_acc;
            restore_ack <= restore_acc;
            cond_ack    <= cond_acc;

            if (cond_acc) begin
                cond_taken <= cond_eval(cond_sel, flags_out);
            end

            if (save_acc && stk_full) begin
                stk_err[0] <= 1'b1;
            end
            if (restore_acc && stk_empty) begin
                stk_err[1] <= 1'b1;
            end

            if (restore_acc) begin
                if (!stk_empty) begin
                    flags_out <= stk_top;
                end
                state <= IDLE;
            end else if (flag_wr) begin
                flags_out <= flag_wr_data;
                state     <= IDLE;
            end else begin
                flags_out[FLAG_Z] <= (a_out == 16'h0000);
                flags_out[FLAG_S] <= a_out[15];
                case (state)
                    PEND_ALU: flags_out[FLAG_C] <= alu_c_flag;
                    PEND_A:   flags_out[FLAG_C] <= a_c_flag;
                    default:  ;
                endcase
                if (alu_op) begin
                    state <= PEND_ALU;
                end else if (a_op) begin
                    state <= PEND_A;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flag_ctrl
// Directed bench for flag_ctrl. Each stimulus row drives one cycle of inputs
// and queues the hand-computed output vector expected after the next rising
// edge. A separate monitor pops the expectation for the current cycle on the
// falling edge; cycles with no queued expectation must show no ack pulses.
// Vector layout: {flags_out[2:0], busy, stk_err[1:0], save_ack, restore_ack,
//                 cond_ack, cond_taken}
// ---------------------------------------------------------------------------
module tb_flag_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] a_out;
    logic        alu_op;
    logic        a_op;
    logic        alu_c_flag;
    logic        a_c_flag;
    logic        flag_wr;
    logic [2:0]  flag_wr_data;
    logic        save_req;
    logic        save_ack;
    logic        restore_req;
    logic        restore_ack;
    logic        cond_req;
    logic [2:0]  cond_sel;
    logic        cond_ack;
    logic        cond_taken;
    logic [2:0]  flags_out;
    logic        busy;
    logic [1:0]  stk_err;

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    flag_ctrl #(
        .STACK_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_out        (a_out),
        .alu_op       (alu_op),
        .a_op         (a_op),
        .alu_c_flag   (alu_c_flag),
        .a_c_flag     (a_c_flag),
        .flag_wr      (flag_wr),
        .flag_wr_data (flag_wr_data),
        .save_req     (save_req),
        .save_ack     (save_ack),
        .restore_req  (restore_req),
        .restore_ack  (restore_ack),
        .cond_req     (cond_req),
        .cond_sel     (cond_sel),
        .cond_ack     (cond_ack),
        .cond_taken   (cond_taken),
        .flags_out    (flags_out),
        .busy         (busy),
        .stk_err      (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Wait for the falling edge, then drive one cycle of inputs.
    task automatic applyStimulus(input logic r, input logic [15:0] a,
                                 input logic alu, input logic aop,
                                 input logic calu, input logic ca,
                                 input logic wr, input logic [2:0] wd,
                                 input logic sreq, input logic rreq,
                                 input logic creq, input logic [2:0] csel);
        @(negedge clk);
        rst          = r;
        a_out        = a;
        alu_op       = alu;
        a_op         = aop;
        alu_c_flag   = calu;
        a_c_flag     = ca;
        flag_wr      = wr;
        flag_wr_data = wd;
        save_req     = sreq;
        restore_req  = rreq;
        cond_req     = creq;
        cond_sel     = csel;
    endtask

    // Queue the outputs expected after the coming rising edge.
    task automatic checkOutput(input string name, input logic [2:0] f,
                               input logic b, input logic [1:0] e,
                               input logic sa, input logic ra,
                               input logic caa, input logic tk);
        exp_t x;
        x.cyc  = cyc + 1;
        x.name = name;
        x.val  = {f, b, e, sa, ra, caa, tk};
        exp_q.push_back(x);
    endtask

    // Monitor: compare against the expectation scheduled for this cycle.
    always @(negedge clk) begin
        logic [9:0] act;
        exp_t       x;
        act = {flags_out, busy, stk_err, save_ack, restore_ack, cond_ack, cond_taken};
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                     x.name, x.cyc, cyc);
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            x = exp_q.pop_front();
            checks++;
            if (act !== x.val) begin
                errors++;
                $display("[TB] FAIL %s: got %b expected %b (flags,busy,err,sack,rack,cack,taken)",
                         x.name, act, x.val);
            end
        end else begin
            checks++;
            if ({save_ack, restore_ack, cond_ack} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL idle_acks: got %b expected 000 at cycle %0d",
                         {save_ack, restore_ack, cond_ack}, cyc);
            end
        end
    end

    initial begin
        rst = 1'b1; a_out = '0; alu_op = 0; a_op = 0; alu_c_flag = 0; a_c_flag = 0;
        flag_wr = 0; flag_wr_data = '0; save_req = 0; restore_req = 0;
        cond_req = 0; cond_sel = '0;

        // Reset and Z/S tracking
        applyStimulus(1, 16'h0000, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("reset",           3'b001,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("zs_track",        3'b100,0,2'b00,0,0,0,0);

        // Carry FSM: simultaneous ops, then a back-to-back stream
        applyStimulus(0, 16'h8001, 1,1,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("op_both_pend",    3'b100,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,1,0, 0,3'b000, 0,0,0,3'd0); checkOutput("alu_wins_commit", 3'b110,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 1,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("stream_issue",    3'b110,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,1,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("stream_alu_c0",   3'b100,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 1,0,0,1, 0,3'b000, 0,0,0,3'd0); checkOutput("stream_a_c1",     3'b110,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,1, 0,3'b000, 0,0,0,3'd0); checkOutput("stream_alu_c0b",  3'b100,0,2'b00,0,0,0,0);

        // Condition queries: stall while busy, ack-cycle block, hold
        applyStimulus(0, 16'h8001, 0,1,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("cond_pend",       3'b100,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,1, 0,3'b000, 0,0,1,3'd3); checkOutput("cond_stall",      3'b110,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,1,3'd3); checkOutput("cond_c_ack",      3'b110,0,2'b00,0,0,1,1);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("cond_ack_pulse",  3'b110,0,2'b00,0,0,0,1);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,1,3'd1); checkOutput("cond_z",          3'b110,0,2'b00,0,0,1,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("cond_hold0",      3'b110,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,1,3'd5); checkOutput("cond_s",          3'b110,0,2'b00,0,0,1,1);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,1,3'd7); checkOutput("cond_ack_block",  3'b110,0,2'b00,0,0,0,1);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,1,3'd7); checkOutput("cond_never",      3'b110,0,2'b00,0,0,1,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("cond_idle",       3'b110,0,2'b00,0,0,0,0);

        // Five saves into a 4-deep stack; flag_wr sets up distinct values
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b011, 1,0,0,3'd0); checkOutput("save1",           3'b011,0,2'b00,1,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b101, 0,0,0,3'd0); checkOutput("wr_101",          3'b101,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b000, 1,0,0,3'd0); checkOutput("save2",           3'b000,0,2'b00,1,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b111, 0,0,0,3'd0); checkOutput("wr_111",          3'b111,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b010, 1,0,0,3'd0); checkOutput("save3",           3'b010,0,2'b00,1,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b001, 0,0,0,3'd0); checkOutput("wr_001",          3'b001,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b100, 1,0,0,3'd0); checkOutput("save4",           3'b100,0,2'b00,1,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 1,3'b011, 0,0,0,3'd0); checkOutput("wr_011",          3'b011,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 1,0,0,3'd0); checkOutput("save_overflow",   3'b110,0,2'b01,1,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("save_ovf_idle",   3'b110,0,2'b01,0,0,0,0);

        // Restores in LIFO order, then underflow with flags untouched
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("restore1",        3'b001,0,2'b01,0,1,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("restore1_track",  3'b100,0,2'b01,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("restore2",        3'b111,0,2'b01,0,1,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("restore2_track",  3'b110,0,2'b01,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("restore3",        3'b101,0,2'b01,0,1,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("restore3_track",  3'b100,0,2'b01,0,0,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("restore4",        3'b110,0,2'b01,0,1,0,0);
        applyStimulus(0, 16'h8001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("restore4_track",  3'b110,0,2'b01,0,0,0,0);
        applyStimulus(0, 16'h0000, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("restore_underflow", 3'b110,0,2'b11,0,1,0,0);
        applyStimulus(0, 16'h0000, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("track_zero",      3'b011,0,2'b11,0,0,0,0);

        // Save/restore/flag_wr collision with one entry on the stack
        applyStimulus(0, 16'h0000, 0,0,0,0, 0,3'b000, 1,0,0,3'd0); checkOutput("save_one",        3'b011,0,2'b11,1,0,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("track_one",       3'b010,0,2'b11,0,0,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 1,3'b110, 1,1,0,3'd0); checkOutput("collide_restore", 3'b011,0,2'b11,0,1,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 0,3'b000, 1,0,0,3'd0); checkOutput("collide_save",    3'b010,0,2'b11,1,0,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("collide_idle",    3'b010,0,2'b11,0,0,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 0,3'b000, 0,1,0,3'd0); checkOutput("collide_popchk",  3'b011,0,2'b11,0,1,0,0);
        applyStimulus(0, 16'h0001, 0,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("collide_track",   3'b010,0,2'b11,0,0,0,0);

        // Reset while PEND_A with a save waiting
        applyStimulus(0, 16'h0001, 0,1,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("rst_pend_a",      3'b010,1,2'b11,0,0,0,0);
        applyStimulus(1, 16'h0001, 0,0,0,0, 0,3'b000, 1,0,0,3'd0); checkOutput("rst_abort",       3'b001,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h0000, 0,0,0,1, 0,3'b000, 0,0,0,3'd0); checkOutput("rst_no_commit",   3'b001,0,2'b00,0,0,0,0);

        // flag_wr discards a pending carry
        applyStimulus(0, 16'h0000, 1,0,0,0, 0,3'b000, 0,0,0,3'd0); checkOutput("wr_pend",         3'b001,1,2'b00,0,0,0,0);
        applyStimulus(0, 16'h0000, 0,0,1,0, 1,3'b100, 0,0,0,3'd0); checkOutput("wr_discard",      3'b100,0,2'b00,0,0,0,0);
        applyStimulus(0, 16'h8000, 0,0,1,0, 0,3'b000, 0,0,0,3'd0); checkOutput("wr_track",        3'b100,0,2'b00,0,0,0,0);

        applyStimulus(0, 16'h8000, 0,0,0,0, 0,3'b000, 0,0,0,3'd0);
        applyStimulus(0, 16'h8000, 0,0,0,0, 0,3'b000, 0,0,0,3'd0);
        applyStimulus(0, 16'h8000, 0,0,0,0, 0,3'b000, 0,0,0,3'd0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_ctrl.md
FLAG_CTRL -- requirements
Module: flag_ctrl

Interface
REQ-001 Parameter STACK_DEPTH, default 4, is the flag save-stack depth in entries.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset; synchronous and active-high.
REQ-004 Port a_out, input, 16: accumulator value; source of Z and S.
REQ-005 Ports alu_op and a_op, input, 1 each: ALU or A-unit op issued this cycle; each requests a carry update.
REQ-006 Ports alu_c_flag and a_c_flag, input, 1 each: carry results, valid the cycle after the matching op.
REQ-007 Ports flag_wr, input, 1, and flag_wr_data, input, 3: explicit whole-flag write (SETF/CLRF instructions).
REQ-008 Ports save_req, input, 1, and save_ack, output, 1: push-flags handshake for interrupt entry.
REQ-009 Ports restore_req, input, 1, and restore_ack, output, 1: pop-flags handshake for interrupt exit.
REQ-010 Ports cond_req, input, 1; cond_sel, input, 3; cond_ack, output, 1; cond_taken, output, 1: branch-condition query.
REQ-011 Ports flags_out, output, 3 ({S,C,Z}); busy, output, 1 (carry pending); stk_err, output, 2 ({underflow,overflow}, sticky).

Function
REQ-012 Each edge with no higher-priority event SHALL load Z from (a_out==0) and S from a_out[15], a 1-cycle latency.
REQ-013 Carry FSM states SHALL be IDLE, PEND_ALU and PEND_A; an edge with alu_op=1 enters PEND_ALU, otherwise an edge with a_op=1 enters PEND_A, otherwise the FSM enters IDLE.
REQ-014 alu_op SHALL win over a_op when both are asserted; the losing a_op is dropped.
REQ-015 In PEND_ALU or PEND_A, the next edge SHALL commit alu_c_flag or a_c_flag, respectively, into C, while REQ-013 captures any new op at the same edge (back-to-back ops, one commit per cycle).
REQ-016 busy SHALL be 1 exactly when the FSM is not IDLE.
REQ-017 Per-edge priority: rst > restore > flag_wr > save > carry commit and Z/S tracking.
REQ-018 Restore (restore_req=1 and restore_ack=0, stack non-empty) SHALL load all flags from the top entry, pop, and force IDLE.
REQ-019 Restore with an empty stack SHALL leave flags unchanged, set stk_err[1], and still ack.
REQ-020 flag_wr SHALL load flags from flag_wr_data and force IDLE, discarding the pending carry commit.
REQ-021 Save (save_req=1 and save_ack=0) SHALL push current flags_out; if the stack holds STACK_DEPTH entries, it SHALL discard the push, set stk_err[0], and still ack.
REQ-022 Save is blocked while busy=1 or while a restore is accepted that edge; the requester holds save_req until acked.
REQ-023 Save does not block Z/S tracking or carry commit in the same edge.
REQ-024 Each ack SHALL be a registered pulse lasting exactly one cycle after acceptance; the requester deasserts its request in the ack cycle; an ack=1 cycle never accepts a request.
REQ-025 A condition query SHALL be accepted when cond_req=1, cond_ack=0, busy=0, and neither flag_wr nor restore is accepted that edge; otherwise it stalls.
REQ-026 On acceptance, cond_taken SHALL be registered alongside a 1-cycle cond_ack pulse.
REQ-027 cond_sel encoding: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 !S, 7 never; cond_taken is evaluated on flags_out as held before that edge.
REQ-028 cond_taken SHALL hold its value until the next accepted query.

Reset
REQ-029 While rst=1 at an edge: flags_out=3'b001 (Z=1), FSM=IDLE, stack empty, stk_err=0, all acks=0, cond_taken=0.
REQ-030 Reset mid-handshake or with a carry pending SHALL abort the operation with no commit and no ack.

Structure
REQ-031 Package meh16_flags_pkg SHALL hold FLAG_Z=0, FLAG_C=1, FLAG_S=2, the cond_sel codes, the FSM state enum and the default STACK_DEPTH.
REQ-032 Sub-module flag_stack (STACK_DEPTH x 3 LIFO with push, pop, full, empty, top) SHALL be instantiated once; the rest stays in flag_ctrl.

Verification
REQ-033 Reset, then a_out=0x8001 for one cycle: flags_out={S=1,C=0,Z=0} one cycle later; busy=0.
REQ-034 alu_op and a_op together with alu_c_flag=1, a_c_flag=0 next cycle: C=1 after the second edge; then an alu_op/a_op stream on consecutive cycles commits one carry per cycle.
REQ-035 cond_req (cond_sel=3) raised while busy=1: cond_ack is held off until busy=0, then pulses with cond_taken equal to the committed C.
REQ-036 Five saves with STACK_DEPTH=4: the fifth acks and sets stk_err[0]; four restores return the pushed values in LIFO order; a fifth restore sets stk_err[1] and leaves flags unchanged.
REQ-037 save_req, restore_req and flag_wr=3'b110 in the same cycle: restore applies and acks, the save stalls one cycle and then acks, and flag_wr is lost.
REQ-038 rst asserted during PEND_A: no carry commit, flags_out=3'b001, no ack.
